// File: rtl/data_table_dispatch.sv
// data_table_dispatch: opcode dispatcher with engine ownership, data-RAM port mux and RAM-clear sequencer.
// Optional DT_CONFLICT_CNT_EN adds a saturating conflict-cycle counter output.
module data_table_dispatch #(
  parameter int DIR_CNT      = 3,
  parameter int OPCODE_WIDTH = 2,
  parameter int A_WIDTH      = 10,
  parameter int D_WIDTH      = 64,
  parameter int BUSY_LAT     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [OPCODE_WIDTH-1:0]    cmd_opcode_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  output logic                       cmd_drop_o,
  output logic [DIR_CNT-1:0]         task_valid_o,
  input  logic [DIR_CNT-1:0]         task_ready_i,
  input  logic [DIR_CNT-1:0]         busy_i,
  input  logic [DIR_CNT-1:0]         eng_rd_en_i,
  input  logic [DIR_CNT*A_WIDTH-1:0] eng_rd_addr_i,
  input  logic [DIR_CNT-1:0]         eng_wr_en_i,
  input  logic [DIR_CNT*A_WIDTH-1:0] eng_wr_addr_i,
  input  logic [DIR_CNT*D_WIDTH-1:0] eng_wr_data_i,
  output logic                       ram_rd_en_o,
  output logic [A_WIDTH-1:0]         ram_rd_addr_o,
  output logic                       ram_wr_en_o,
  output logic [A_WIDTH-1:0]         ram_wr_addr_o,
  output logic [D_WIDTH-1:0]         ram_wr_data_o,
  input  logic                       clear_run_i,
  output logic                       clear_busy_o,
  output logic                       clear_done_o,
`ifdef DT_CONFLICT_CNT_EN
  output logic [15:0]                conflict_cnt_o,
`endif
  output logic                       conflict_o
);
  localparam int OW = DIR_CNT > 1 ? $clog2(DIR_CNT) : 1;
  localparam int HW = $clog2(BUSY_LAT + 2);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic owner_vld;
  logic [OW-1:0] owner;
  logic [HW-1:0] hold;
  logic [A_WIDTH-1:0] clr_addr;
  logic valid_op, owner_ok, accept, drop_nx, conflict_now;
  always_comb begin
    valid_op = int'(cmd_opcode_i) < DIR_CNT;
    owner_ok = !owner_vld || int'(owner) == int'(cmd_opcode_i);
    task_valid_o = '0;
    cmd_ready_o = 1'b0;
    if (state == IDLE) begin
      cmd_ready_o = !valid_op;
      for (int k = 0; k < DIR_CNT; k++)
        if (int'(cmd_opcode_i) == k && owner_ok) begin
          task_valid_o[k] = cmd_valid_i;
          cmd_ready_o = task_ready_i[k];
        end
    end
    accept  = cmd_valid_i && cmd_ready_o && valid_op;
    drop_nx = cmd_valid_i && cmd_ready_o && !valid_op;
    state_nx = state == IDLE ? (clear_run_i && !owner_vld ? CLEAR : IDLE)
                             : (&clr_addr ? IDLE : CLEAR);
  end
  // Lowest-index engine wins each port; the clear sequencer overrides the write port.
  always_comb begin
    ram_rd_en_o = 1'b0;
    ram_rd_addr_o = '0;
    ram_wr_en_o = 1'b0;
    ram_wr_addr_o = '0;
    ram_wr_data_o = '0;
    for (int k = DIR_CNT - 1; k >= 0; k--) begin
      if (eng_rd_en_i[k]) begin
        ram_rd_en_o = 1'b1;
        ram_rd_addr_o = eng_rd_addr_i[k*A_WIDTH +: A_WIDTH];
      end
      if (eng_wr_en_i[k]) begin
        ram_wr_en_o = 1'b1;
        ram_wr_addr_o = eng_wr_addr_i[k*A_WIDTH +: A_WIDTH];
        ram_wr_data_o = eng_wr_data_i[k*D_WIDTH +: D_WIDTH];
      end
    end
    if (state == CLEAR) begin
      ram_wr_en_o = 1'b1;
      ram_wr_addr_o = clr_addr;
      ram_wr_data_o = '0;
    end
    conflict_now = $countones(eng_rd_en_i) > 1 || $countones(eng_wr_en_i) > 1 ||
                   (state == CLEAR && |eng_wr_en_i);
    clear_busy_o = state == CLEAR;
    clear_done_o = state == CLEAR && &clr_addr;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      owner_vld <= 1'b0;
      owner <= '0;
      hold <= '0;
      clr_addr <= '0;
      cmd_drop_o <= 1'b0;
      conflict_o <= 1'b0;
    end else begin
      state <= state_nx;
      clr_addr <= state == CLEAR ? clr_addr + A_WIDTH'(1) : '0;
      cmd_drop_o <= drop_nx;
      conflict_o <= conflict_o | conflict_now;
      if (accept) begin
        owner <= OW'(cmd_opcode_i);
        owner_vld <= 1'b1;
        hold <= HW'(BUSY_LAT);
      end else if (owner_vld) begin
        if (hold != '0) hold <= hold - HW'(1);
        else if (!busy_i[owner]) owner_vld <= 1'b0;
      end
    end
  end
`ifdef DT_CONFLICT_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) conflict_cnt_o <= '0;
    else if (conflict_now && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_data_table_dispatch.sv
// tb_data_table_dispatch: directed vector table plus hand sequences for ownership, drop, clear and conflict.
module tb_data_table_dispatch;
  localparam int A = 4, D = 64, N = 3;
  logic clk = 0, rst_n = 0;
  logic [1:0] op;
  logic vld, rdy, drop, rd_en_o, wr_en_o, clr, clr_busy, clr_done, conflict;
  logic [N-1:0] tv, tr, busy, rd_en, wr_en;
  logic [N*A-1:0] rd_addr, wr_addr;
  logic [N*D-1:0] wr_data;
  logic [A-1:0] rd_addr_o, wr_addr_o;
  logic [D-1:0] wr_data_o;
`ifdef DT_CONFLICT_CNT_EN
  logic [15:0] cnt;
`endif
  data_table_dispatch #(.DIR_CNT(N), .OPCODE_WIDTH(2), .A_WIDTH(A), .D_WIDTH(D), .BUSY_LAT(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_opcode_i(op), .cmd_valid_i(vld), .cmd_ready_o(rdy),
    .cmd_drop_o(drop), .task_valid_o(tv), .task_ready_i(tr), .busy_i(busy),
    .eng_rd_en_i(rd_en), .eng_rd_addr_i(rd_addr), .eng_wr_en_i(wr_en), .eng_wr_addr_i(wr_addr),
    .eng_wr_data_i(wr_data), .ram_rd_en_o(rd_en_o), .ram_rd_addr_o(rd_addr_o), .ram_wr_en_o(wr_en_o),
    .ram_wr_addr_o(wr_addr_o), .ram_wr_data_o(wr_data_o), .clear_run_i(clr), .clear_busy_o(clr_busy),
    .clear_done_o(clr_done),
`ifdef DT_CONFLICT_CNT_EN
    .conflict_cnt_o(cnt),
`endif
    .conflict_o(conflict));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [1:0] op; logic vld; logic [2:0] tr, rd_en, wr_en;
    logic [11:0] rd_addr, wr_addr; logic [191:0] wr_data;
    logic rdy; logic [2:0] tv; logic erd_en; logic [3:0] erd_addr;
    logic ewr_en; logic [3:0] ewr_addr; logic [63:0] ewr_data;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle_in();
    op = 0; vld = 0; tr = 0; busy = 0; rd_en = 0; wr_en = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; clr = 0;
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  initial begin
    logic [11:0] ad;
    logic [191:0] dt;
    ad = {4'd1, 4'd7, 4'd2};
    dt = {64'hAAAA, 64'hBBBB, 64'hCCCC};
    vt[0] = '{2'd1, 1, 3'b010, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0};
    vt[1] = '{2'd0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0};
    vt[2] = '{2'd2, 1, 3'b100, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0, 0, 0};
    vt[3] = '{2'd3, 1, 3'b000, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0};
    vt[4] = '{2'd1, 0, 3'b010, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0};
    vt[5] = '{2'd0, 0, 3'b000, 3'b010, 3'b100, ad, {4'd3, 4'd8, 4'd9}, dt, 0, 0, 1, 4'd7, 1, 4'd3, 64'hAAAA};
    vt[6] = '{2'd0, 0, 3'b000, 3'b000, 3'b001, ad, {4'd3, 4'd8, 4'd9}, dt, 0, 0, 0, 4'd0, 1, 4'd9, 64'hCCCC};
    vt[7] = '{2'd0, 0, 3'b000, 3'b000, 3'b000, ad, {4'd3, 4'd8, 4'd9}, dt, 0, 0, 0, 4'd0, 0, 4'd0, 64'h0};
    vt[8] = '{2'd0, 0, 3'b000, 3'b100, 3'b010, ad, {4'd3, 4'd8, 4'd9}, dt, 0, 0, 1, 4'd1, 1, 4'd8, 64'hBBBB};
    idle_in();
    #12 rst_n = 1;
    cyc(1); #1;
    chk("rst_ready", rdy, 0); chk("rst_tv", tv, 0); chk("rst_drop", drop, 0);
    chk("rst_clr_busy", clr_busy, 0); chk("rst_clr_done", clr_done, 0);
    chk("rst_conflict", conflict, 0); chk("rst_wr_en", wr_en_o, 0); chk("rst_rd_en", rd_en_o, 0);
`ifdef DT_CONFLICT_CNT_EN
    chk("rst_cnt", cnt, 0);
`endif
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      op = vt[i].op; vld = vt[i].vld; tr = vt[i].tr; rd_en = vt[i].rd_en; wr_en = vt[i].wr_en;
      rd_addr = vt[i].rd_addr; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      #1;
      chk($sformatf("v%0d_ready", i), rdy, vt[i].rdy);
      chk($sformatf("v%0d_tv", i), tv, vt[i].tv);
      chk($sformatf("v%0d_rd_en", i), rd_en_o, vt[i].erd_en);
      chk($sformatf("v%0d_rd_addr", i), rd_addr_o, vt[i].erd_addr);
      chk($sformatf("v%0d_wr_en", i), wr_en_o, vt[i].ewr_en);
      chk($sformatf("v%0d_wr_addr", i), wr_addr_o, vt[i].ewr_addr);
      chk($sformatf("v%0d_wr_data", i), wr_data_o, vt[i].ewr_data);
      chk($sformatf("v%0d_conflict", i), conflict, 0);
      cyc(1); idle_in(); cyc(5);
    end
    // ownership: BUSY_LAT hold with busy low, then busy extension
    cyc(1); op = 1; vld = 1; tr = 3'b010; #1;
    chk("own_tv1", tv, 3'b010); chk("own_rdy1", rdy, 1);
    cyc(1); op = 0; tr = 3'b111;
    for (int j = 0; j < 3; j++) begin
      #1; chk($sformatf("own_hold%0d_rdy", j), rdy, 0); chk($sformatf("own_hold%0d_tv", j), tv, 0);
      cyc(1);
    end
    #1; chk("own_rel_rdy", rdy, 1); chk("own_rel_tv", tv, 3'b001);
    cyc(1); #1; chk("own_same_rdy", rdy, 1); chk("own_same_tv", tv, 3'b001);
    cyc(1); op = 1; busy = 3'b001;
    for (int j = 0; j < 6; j++) begin
      #1; chk($sformatf("own_busy%0d_rdy", j), rdy, 0); chk($sformatf("own_busy%0d_tv", j), tv, 0);
      cyc(1);
    end
    busy = 0; #1; chk("own_last_rdy", rdy, 0);
    cyc(1); #1; chk("own_free_rdy", rdy, 1); chk("own_free_tv", tv, 3'b010);
    idle_in(); cyc(6);
    // drop: opcode 3 accepted, owner unchanged
    op = 1; vld = 1; tr = 3'b010;
    cyc(1); op = 3; #1; chk("drop_rdy", rdy, 1); chk("drop_tv", tv, 0);
    cyc(1); op = 0; tr = 3'b001; #1;
    chk("drop_pulse", drop, 1); chk("drop_owner_rdy", rdy, 0); chk("drop_owner_tv", tv, 0);
    cyc(1); vld = 0; #1; chk("drop_end", drop, 0);
    idle_in(); cyc(6);
    // clear request ignored while an owner is held
    op = 2; vld = 1; tr = 3'b100;
    cyc(1); vld = 0; clr = 1;
    cyc(1); #1; chk("clr_ign_busy", clr_busy, 0);
    idle_in(); cyc(6);
    // full clear, with an engine write and read injected mid-sequence
    clr = 1;
    cyc(1); clr = 0; op = 0; tr = 3'b001; vld = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        wr_en = 3'b001; wr_addr = 12'h00F; wr_data = 192'hFFFF;
        rd_en = 3'b001; rd_addr = 12'h009;
      end
      if (i == 4) begin
        wr_en = 0; rd_en = 0;
      end
      #1;
      chk($sformatf("clr%0d_wr_en", i), wr_en_o, 1);
      chk($sformatf("clr%0d_addr", i), wr_addr_o, i);
      chk($sformatf("clr%0d_data", i), wr_data_o, 0);
      chk($sformatf("clr%0d_busy", i), clr_busy, 1);
      chk($sformatf("clr%0d_done", i), clr_done, i == 15);
      chk($sformatf("clr%0d_rdy", i), rdy, 0);
      chk($sformatf("clr%0d_tv", i), tv, 0);
      if (i == 3) begin
        chk("clr_rd_en", rd_en_o, 1); chk("clr_rd_addr", rd_addr_o, 9);
      end
      if (i == 4) chk("clr_wr_conflict", conflict, 1);
      cyc(1);
    end
    #1; chk("clr_end_busy", clr_busy, 0); chk("clr_end_done", clr_done, 0);
    chk("clr_end_rdy", rdy, 1); chk("clr_end_conflict", conflict, 1);
    idle_in(); cyc(6);
    // reset in the middle of a clear
    clr = 1;
    cyc(1); clr = 0;
    cyc(7); #1; chk("mid_addr", wr_addr_o, 7);
    rst_n = 0; #1;
    chk("mid_busy", clr_busy, 0); chk("mid_done", clr_done, 0); chk("mid_wr_en", wr_en_o, 0);
    chk("mid_conflict", conflict, 0); chk("mid_drop", drop, 0);
`ifdef DT_CONFLICT_CNT_EN
    chk("mid_cnt", cnt, 0);
`endif
    cyc(2); #1; chk("mid_hold_done", clr_done, 0); chk("mid_hold_busy", clr_busy, 0);
    rst_n = 1;
    cyc(1); #1; chk("mid_after_busy", clr_busy, 0);
    // read-port conflict: lowest index wins, sticky flag
    cyc(1); rd_en = 3'b110; rd_addr = {4'd9, 4'd5, 4'd0}; #1;
    chk("cf_rd_addr", rd_addr_o, 5); chk("cf_rd_en", rd_en_o, 1); chk("cf_before", conflict, 0);
    cyc(1); rd_en = 0; #1; chk("cf_set", conflict, 1);
    cyc(3); #1; chk("cf_sticky", conflict, 1);
`ifdef DT_CONFLICT_CNT_EN
    chk("cf_cnt", cnt, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
